fetch_unit: RTL and testbench



---
 rtl/proc_pkg.sv | 16 +
 rtl/fetch_unit_pc_reg.sv | 26 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch state encoding and opcode field layout.
// The control FSM decodes the same opcode field, so both sides import this package.
// No logic; constants and types only.
package proc_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // Opcode occupies the top OP_W bits of every instruction word.
    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] HALT_OPCODE = 4'hF;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Loadable, incrementing, wrapping program counter register.
// Latency: q updates on the clk edge after load/inc; load has priority over inc.
// Backpressure: none; holds value when neither load nor inc is asserted.
module pc_reg #(
    parameter int              W       = 8,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, latches ROM words and hands them over valid/ready.
// Latency: first instr_valid one cycle after reset release; one word per cycle sustained.
// Backpressure: instr held stable while instr_ready=0; jump costs one bubble cycle.
module fetch_unit
    import proc_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                INSTR_W    = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [OP_W-1:0]   HALT_OP    = HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  address,
    input  logic [INSTR_W-1:0] code,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               halt,
    output logic [15:0]        retired
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic              accept;
    logic              take_jump;
    logic              capture;
    logic              halt_word;
    logic              pc_load;
    logic              pc_inc;

    assign address   = pc;
    assign accept    = instr_valid & instr_ready;
    assign halt_word = (code[INSTR_W-1 -: OP_W] == HALT_OP);

    // A jump on an accept cycle discards the word at pc, so it suppresses capture
    // and therefore also HALT detection of that word.
    assign take_jump = (state == HOLD) & accept & jump_en;
    assign capture   = (state == FETCH) | ((state == HOLD) & accept & ~jump_en);

    assign pc_load = take_jump;
    assign pc_inc  = capture & ~halt_word;

    pc_reg #(
        .W       (ADDR_W),
        .RST_VAL (START_ADDR)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .inc  (pc_inc),
        .d    (jump_addr),
        .q    (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halt        <= 1'b0;
            retired     <= '0;
        end else begin
            if (accept && (retired != 16'hFFFF)) begin
                retired <= retired + 16'd1;
            end

            case (state)
                FETCH, HOLD: begin
                    if (take_jump) begin
                        state       <= FETCH;
                        instr_valid <= 1'b0;
                    end else if (capture) begin
                        if (halt_word) begin
                            state       <= HALT;
                            instr_valid <= 1'b0;
                            halt        <= 1'b1;
                        end else begin
                            state       <= HOLD;
                            instr       <= code;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    instr_valid <= 1'b0;
                    halt        <= 1'b1;
                end
                default: begin
                    state       <= FETCH;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a behavioural fetch model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  address;
    logic [15:0] code;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic [7:0]  instr_pc;
    logic        halt;
    logic [15:0] retired;

    logic [15:0] rom [0:255];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model of the architecturally visible fetch behaviour.
    logic [7:0]  m_pc;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [7:0]  m_ipc;
    logic        m_halt;
    logic [15:0] m_ret;

    always #5 clk = ~clk;

    assign code = rom[address];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .code        (code),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .instr_pc    (instr_pc),
        .halt        (halt),
        .retired     (retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        logic        acc;
        logic [15:0] w;
        if (rst) begin
            m_pc = 8'h00; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
            m_halt = 1'b0; m_ret = '0;
        end else if (!m_halt) begin
            acc = m_valid && instr_ready;
            if (acc && m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
            if (acc && jump_en) begin
                m_pc    = jump_addr;
                m_valid = 1'b0;
            end else if (!m_valid || acc) begin
                w = rom[m_pc];
                if (w[15:12] == 4'hF) begin
                    m_halt  = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_instr = w;
                    m_ipc   = m_pc;
                    m_pc    = m_pc + 8'd1;
                    m_valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("address", address, m_pc);
            check("instr_valid", instr_valid, m_valid);
            check("halt", halt, m_halt);
            check("retired", retired, m_ret);
            if (m_valid) begin
                check("instr", instr, m_instr);
                check("instr_pc", instr_pc, m_ipc);
            end
        end
    end

    task automatic fill_rom(input int halt_one_in);
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (halt_one_in > 0 && $urandom_range(0, halt_one_in - 1) == 0)
                w[15:12] = 4'hF;
            else
                w[15:12] = 4'($urandom_range(0, 14));
            rom[i] = w;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; instr_ready = 1'b0; jump_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
        fill_rom(0);
        rom[0] = 16'h1234;
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_valid", instr_valid, 0);
        check("rst_halt", halt, 0);
        check("rst_retired", retired, 0);
        check("rst_address", address, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);

        // First fetch after reset release.
        rst = 1'b0;
        tick();
        check("first_instr", instr, 16'h1234);
        check("first_valid", instr_valid, 1);
        check("first_instr_pc", instr_pc, 0);
        check("first_address", address, 1);

        // Backpressure, ignored jump while stalled, then jump with one bubble.
        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        rom[8'h40] = 16'h5A5A;
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            jump_en = (i % 2 == 0); jump_addr = 8'h77;
            tick();
            check("stall_instr", instr, 16'h1111);
            check("stall_address", address, 1);
        end
        jump_en = 1'b0; instr_ready = 1'b1;
        tick();
        check("bp_instr2", instr, 16'h2222);
        tick();
        check("bp_instr3", instr, 16'h3333);
        check("bp_retired", retired, 2);
        tick();
        check("pc3_instr_pc", instr_pc, 3);
        jump_en = 1'b1; jump_addr = 8'h40;
        tick();
        check("jump_bubble_valid", instr_valid, 0);
        check("jump_bubble_address", address, 8'h40);
        jump_en = 1'b0; instr_ready = 1'b0;
        tick();
        check("jump_instr", instr, 16'h5A5A);
        check("jump_instr_pc", instr_pc, 8'h40);
        check("jump_valid", instr_valid, 1);

        // Halt on ROM[5] with continuous acceptance.
        for (int i = 0; i < 5; i++) rom[i] = 16'h0100 + 16'(i);
        rom[5] = 16'hF000;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("halt_flag", halt, 1);
        check("halt_valid", instr_valid, 0);
        check("halt_address", address, 5);
        check("halt_retired", retired, 5);
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1'($urandom); jump_en = 1'($urandom); jump_addr = 8'($urandom);
            tick();
            check("halt_stuck_address", address, 5);
            check("halt_stuck_flag", halt, 1);
        end
        do_reset();
        check("halt_rst_address", address, 0);
        check("halt_rst_flag", halt, 0);

        // PC wrap through 8'hFF.
        rom[8'hFE] = 16'hA0FE; rom[8'hFF] = 16'hA0FF; rom[0] = 16'hA000; rom[1] = 16'hA001;
        instr_ready = 1'b0; jump_en = 1'b0;
        tick();
        instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 8'hFE;
        tick();
        jump_en = 1'b0;
        tick();
        check("wrap_pc_fe", instr_pc, 8'hFE);
        tick();
        check("wrap_pc_ff", instr_pc, 8'hFF);
        tick();
        check("wrap_pc_00", instr_pc, 8'h00);
        check("wrap_instr_00", instr, 16'hA000);
        tick();
        check("wrap_pc_01", instr_pc, 8'h01);

        // Reset in HOLD overrides an accepting jump.
        rst = 1'b1; instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 8'h99;
        tick();
        check("midrst_address", address, 0);
        check("midrst_valid", instr_valid, 0);
        check("midrst_retired", retired, 0);
        rst = 1'b0; jump_en = 1'b0; instr_ready = 1'b0;

        // Saturation of the retired counter.
        fill_rom(0);
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        check("retired_sat", retired, 16'hFFFF);

        // Random traffic with occasional HALT words and resets.
        fill_rom(40);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            instr_ready = ($urandom_range(0, 9) < 7);
            jump_en     = ($urandom_range(0, 9) == 0);
            jump_addr   = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
